// File: rtl/m_dm_ctrl_pkg.sv
// m_dm_ctrl_pkg
//   Shared definitions for the M-stage data-memory controller:
//   load/store size codes, FSM state encoding, timeout counter width and
//   the access legality/alignment check.
package m_dm_ctrl_pkg;

  // Size / extension codes carried by cpu_op (stores reuse 0..2 as sw/sh/sb)
  localparam logic [2:0] DE_lw  = 3'd0;
  localparam logic [2:0] DE_lh  = 3'd1;
  localparam logic [2:0] DE_lb  = 3'd2;
  localparam logic [2:0] DE_lhu = 3'd3;
  localparam logic [2:0] DE_lbu = 3'd4;

  localparam int DMC_CNT_W = 8;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_REQ  = 2'd1,
    DMC_WAIT = 2'd2,
    DMC_RESP = 2'd3
  } dmc_state_e;

  // True when the access may go to the bus: a known op, not an unsigned
  // store, and naturally aligned for its size.
  function automatic logic f_access_ok(input logic       we,
                                       input logic [2:0] op,
                                       input logic [1:0] lo);
    case (op)
      DE_lw:   return (lo == 2'b00);
      DE_lh:   return !lo[0];
      DE_lb:   return 1'b1;
      DE_lhu:  return !we && !lo[0];
      DE_lbu:  return !we;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_dm_ctrl_load_ext.sv
// m_load_ext
//   Combinational load extender. Picks the addressed halfword/byte out of
//   the bus word and sign- or zero-extends it according to the op code.
// Ports:
//   i_addr_lo  in  2   byte offset within the word
//   i_op       in  3   DE_* size/extension code
//   i_word     in  32  raw word from the bus
//   o_data     out 32  extended load result
module m_load_ext
  import m_dm_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  always_comb begin
    case (i_op)
      DE_lh:   o_data = {{16{w_half[15]}}, w_half};
      DE_lhu:  o_data = {16'h0000, w_half};
      DE_lb:   o_data = {{24{w_byte[7]}}, w_byte};
      DE_lbu:  o_data = {24'h000000, w_byte};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/m_dm_ctrl.sv
// m_dm_ctrl
//   M-stage data-memory access controller. Accepts one load/store per
//   instruction, runs it on a request/grant/response bus, formats store
//   data and byte enables, extends load data, reports misaligned/illegal
//   accesses and bus timeouts, and stalls the pipeline until completion.
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_op  access request from M stage
//   cpu_rdata/cpu_done/cpu_exc                completion (valid in RESP)
//   cpu_stall                                 freeze F/D/E/M
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  bus request (held in REQ)
//   mem_gnt/mem_rvalid/mem_rdata              bus grant and read response
module m_dm_ctrl
  import m_dm_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_op,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_exc,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Counter value seen on the last allowed REQ/WAIT cycle
  localparam logic [DMC_CNT_W-1:0] TMO_LAST = DMC_CNT_W'(TIMEOUT - 1);

  function automatic logic [3:0] f_store_be(input logic       we,
                                            input logic [2:0] op,
                                            input logic [1:0] lo);
    if (!we) return 4'b1111;
    case (op)
      DE_lh:   return lo[1] ? 4'b1100 : 4'b0011;
      DE_lb:   return 4'b0001 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [2:0]  op,
                                               input logic [31:0] wdata);
    case (op)
      DE_lh:   return {2{wdata[15:0]}};
      DE_lb:   return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

  dmc_state_e           r_state;
  dmc_state_e           w_state_nxt;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [2:0]           r_op;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic [DMC_CNT_W-1:0] r_cnt;
  logic [DMC_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]          r_rdata;
  logic                 r_exc;
  logic [31:0]          w_rdata_nxt;
  logic                 w_exc_nxt;
  logic                 w_latch;
  logic                 w_ok;
  logic                 w_tmo_hit;
  logic                 w_in_req;
  logic [31:0]          w_ext;

  m_load_ext u_load_ext (
    .i_addr_lo (r_addr[1:0]),
    .i_op      (r_op),
    .i_word    (mem_rdata),
    .o_data    (w_ext)
  );

  assign w_ok      = f_access_ok(cpu_we, cpu_op, cpu_addr[1:0]);
  assign w_tmo_hit = (r_cnt == TMO_LAST);

  // Completion data is only non-zero on the edge entering RESP, so the
  // registered cpu_rdata/cpu_exc are automatically 0 outside RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdata_nxt = '0;
    w_exc_nxt   = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      DMC_IDLE: begin
        if (cpu_req) begin
          w_latch = 1'b1;
          if (!w_ok) begin
            w_state_nxt = DMC_RESP;
            w_exc_nxt   = 1'b1;
          end else begin
            w_state_nxt = DMC_REQ;
            w_cnt_nxt   = '0;
          end
        end
      end
      DMC_REQ: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A store completes on grant even on the last cycle; a load grant
        // on the last cycle still needs data, so it times out.
        if (mem_gnt && r_we) begin
          w_state_nxt = DMC_RESP;
        end else if (w_tmo_hit) begin
          w_state_nxt = DMC_RESP;
          w_exc_nxt   = 1'b1;
        end else if (mem_gnt) begin
          w_state_nxt = DMC_WAIT;
        end
      end
      DMC_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (mem_rvalid) begin
          w_state_nxt = DMC_RESP;
          w_rdata_nxt = w_ext;
        end else if (w_tmo_hit) begin
          w_state_nxt = DMC_RESP;
          w_exc_nxt   = 1'b1;
        end
      end
      DMC_RESP: begin
        w_state_nxt = DMC_IDLE;
      end
      default: begin
        w_state_nxt = DMC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DMC_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_exc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_op    <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdata <= w_rdata_nxt;
      r_exc   <= w_exc_nxt;
      if (w_latch) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_op    <= cpu_op;
        r_be    <= f_store_be(cpu_we, cpu_op, cpu_addr[1:0]);
        r_wdata <= f_store_data(cpu_op, cpu_wdata);
      end
    end
  end

  assign w_in_req  = (r_state == DMC_REQ);
  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req & r_we;
  assign mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem_be    = w_in_req ? r_be : '0;
  assign mem_wdata = w_in_req ? r_wdata : '0;

  assign cpu_done  = (r_state == DMC_RESP);
  assign cpu_rdata = r_rdata;
  assign cpu_exc   = r_exc;
  // Gated by reset so the stall drops at once when an access is abandoned.
  assign cpu_stall = reset & cpu_req & (r_state != DMC_RESP);

endmodule

// File: tb/tb_m_dm_ctrl.sv
// tb_m_dm_ctrl
//   Scoreboard bench for m_dm_ctrl. A driver issues accesses with chosen
//   grant/response delays and pushes the expected completion and bus
//   request; independent monitors pop and compare.
module tb_m_dm_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_exc, cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  m_dm_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_op(cpu_op),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_exc(cpu_exc),
    .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned done_cyc;
    logic        exc;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  resp_t sb_q[$];
  bus_t  bus_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    req_seen = 0;
  int    exp_req = 0;
  resp_t mon_r;
  logic  mon_exp_stall;
  bus_t  rb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_legal(input logic we, input int op, input logic [31:0] addr);
    int size;
    if (op > 4) return 1'b0;
    if (we && op >= 3) return 1'b0;
    size = (op == 0) ? 4 : ((op == 1 || op == 3) ? 2 : 1);
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      1:       return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      2:       return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
      3:       return h;
      4:       return b;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input int op, input logic [31:0] addr);
    logic [3:0] m;
    case (op)
      1:       m = 4'h3 << (2 * addr[1]);
      2:       m = 4'h1 << addr[1:0];
      default: m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] wdata);
    case (op)
      1:       return (wdata & 32'hFFFF) * 32'h00010001;
      2:       return (wdata & 32'hFF) * 32'h01010101;
      default: return wdata;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Entered on a negedge (cycle 0); returns on the negedge after cpu_done
  // with the CPU side idle, ready for a back-to-back issue.
  task automatic access(input logic we, input int op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int gd, input int rd);
    logic  ok, tmo;
    int    done_k, bus_k;
    resp_t r;
    bus_t  b;
    ok    = ref_legal(we, op, addr);
    tmo   = 1'b0;
    bus_k = gd + 1;
    if (!ok) done_k = 1;
    else if (we) begin
      if (bus_k <= T) done_k = gd + 2;
      else begin done_k = T + 1; tmo = 1'b1; end
    end else begin
      if (gd + rd + 2 <= T) done_k = gd + rd + 3;
      else begin done_k = T + 1; tmo = 1'b1; end
    end
    r.done_cyc = cyc + done_k;
    r.exc      = !ok || tmo;
    r.rdata    = (ok && !we && !tmo) ? ref_load(op, addr, word) : 32'h0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_op    = op[2:0];
    cpu_addr  = addr;
    cpu_wdata = wdata;
    sb_q.push_back(r);
    if (ok) begin
      b.we    = we;
      b.addr  = addr & ~32'h3;
      b.be    = ref_be(op, addr);
      b.wdata = ref_wdata(op, wdata);
      bus_q.push_back(b);
      exp_req += (bus_k < T) ? bus_k : T;
    end
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      mem_rdata  = $urandom;
      mem_gnt    = ok && (k == gd + 1);
      mem_rvalid = ok && !we && (k == gd + rd + 2);
      if (!mem_rvalid && $urandom_range(0, 2) == 0 && (we || !ok || k <= gd + 1))
        mem_rvalid = 1'b1;
      if (!mem_gnt && $urandom_range(0, 2) == 0 && ((ok && !we && k > gd + 1) || k == done_k))
        mem_gnt = 1'b1;
      if (mem_rvalid && ok && !we && k == gd + rd + 2) mem_rdata = word;
    end
    if (ok && bus_k > T) void'(bus_q.pop_front());
    @(negedge clk);
    cpu_req    = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (tmo && !we) begin
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
  endtask

  // ---------------- CPU-side monitor ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (reset) begin
      mon_exp_stall = cpu_req && !(sb_q.size() > 0 && sb_q[0].done_cyc == cyc);
      check("stall", cpu_stall, mon_exp_stall);
      if (cpu_done) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_unexp: cpu_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_r = sb_q.pop_front();
          check("done_cycle", cyc, mon_r.done_cyc);
          check("cpu_exc", cpu_exc, mon_r.exc);
          check("cpu_rdata", cpu_rdata, mon_r.rdata);
        end
      end else begin
        check("resp_idle", cpu_rdata | {31'b0, cpu_exc}, 32'h0);
        if (sb_q.size() > 0 && cyc > sb_q[0].done_cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL done_missing: cpu_done=0 expected 1 at cycle %0d", sb_q[0].done_cyc);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // ---------------- bus-side monitor ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (reset && mem_req) begin
      req_seen++;
      if (bus_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL bus_unexp: mem_req=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("mem_we", mem_we, bus_q[0].we);
        check("mem_addr", mem_addr, bus_q[0].addr);
        if (bus_q[0].we) begin
          check("mem_be", mem_be, bus_q[0].be);
          check("mem_wdata", mem_wdata, bus_q[0].wdata);
        end
        if (mem_gnt) void'(bus_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_op = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {cpu_done, cpu_exc, cpu_stall, mem_req, mem_we, mem_be}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    cpu_req = 1'b1;
    #1 check("rst_stall", cpu_stall, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // directed cases
    access(1'b0, 0, 32'h100, 32'h0, 32'h8000FFFE, 0, 1);
    access(1'b0, 1, 32'h102, 32'h0, 32'h80011234, 0, 0);
    access(1'b0, 3, 32'h102, 32'h0, 32'h80011234, 1, 2);
    access(1'b0, 2, 32'h103, 32'h0, 32'h80011234, 0, 0);
    access(1'b0, 4, 32'h100, 32'h0, 32'h80011234, 2, 0);
    access(1'b1, 1, 32'h102, 32'h0000ABCD, 32'h0, 3, 0);
    access(1'b1, 2, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    access(1'b0, 0, 32'h101, 32'h0, 32'h0, 0, 0);
    access(1'b1, 4, 32'h100, 32'h12345678, 32'h0, 0, 0);
    access(1'b0, 0, 32'h104, 32'h0, 32'h11111111, 0, 20);
    access(1'b1, 0, 32'h108, 32'h55AA55AA, 32'h0, 9, 0);

    // reset asserted while a load waits for data
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_op = 3'd0; cpu_addr = 32'h300;
    rb.we = 1'b0; rb.addr = 32'h300; rb.be = 4'hF; rb.wdata = 32'h0;
    bus_q.push_back(rb);
    exp_req += 1;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 32'h0);
    check("rst_mid_stall", cpu_stall, 32'h0);
    check("rst_mid_done", cpu_done, 32'h0);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    access(1'b1, 0, 32'h200, 32'hDEADBEEF, 32'h0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic        rwe;
      int          rop, rgd, rrd;
      logic [31:0] raddr;
      rwe   = $urandom_range(0, 1);
      rop   = $urandom_range(0, 7);
      raddr = $urandom;
      if ($urandom_range(0, 1) == 1) raddr = raddr & ~32'h3;
      rgd   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 3);
      rrd   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 3);
      access(rwe, rop, raddr, $urandom, $urandom, rgd, rrd);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("req_cycles", req_seen, exp_req);
    check("sb_left", sb_q.size(), 32'h0);
    check("bus_left", bus_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
